// File: rtl/div_sched_pkg.sv
// Shared definitions for the Q16.16 divider scheduler: FSM encoding and fixed-point constants.
package div_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] Q16_ONE = 32'h0001_0000;
  localparam logic [31:0] Q16_SAT = 32'h7FFF_FFFF;

endpackage

// File: rtl/div_sched_if.sv
// Operand/result bus between the scheduler (master) and the shared divider (slave).
interface div_sched_if;

  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_valid;
  logic [31:0] div_quotient;

  modport master (
    output div_dividend,
    output div_divisor,
    input  div_valid,
    input  div_quotient
  );

  modport slave (
    input  div_dividend,
    input  div_divisor,
    output div_valid,
    output div_quotient
  );

endinterface

// File: rtl/div_sched_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester strictly after the last grant, wrapping.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] gnt
);

  localparam logic [N_REQ-1:0] ONE_V = N_REQ'(1);

  logic [N_REQ-1:0] upper_mask;
  logic [N_REQ-1:0] upper_req;

  // Positions above the last grant win first; otherwise wrap to the lowest requester.
  always_comb begin
    upper_mask = ~(last | (last - ONE_V));
    upper_req  = req & upper_mask;
    if (upper_req != '0) begin
      gnt = upper_req & (~upper_req + ONE_V);
    end else begin
      gnt = req & (~req + ONE_V);
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one Q16.16 divider among N_REQ requesters. Requesters hold req/operands until ack;
// the divider signals completion by a rising edge of div_valid. Define DIV_SCHED_TIMEOUT_EN for a WAIT timeout.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  dividend_i,
  input  logic [32*N_REQ-1:0]  divisor_i,
  output logic [N_REQ-1:0]     ack,
  output logic [31:0]          quotient,
  output logic                 warn,
  output logic [31:0]          div_dividend,
  output logic [31:0]          div_divisor,
  input  logic                 div_valid,
  input  logic [31:0]          div_quotient
);

  localparam logic [N_REQ-1:0] LAST_RST = N_REQ'(1) << (N_REQ - 1);

  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] last_grant;
  logic [N_REQ-1:0] pick;
  logic [31:0]      sel_dvd;
  logic [31:0]      sel_dvs;
  logic             valid_q;
  logic             valid_rise;
  logic             start;
  logic             sel_zero;
  logic             timeout_hit;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req),
    .last (last_grant),
    .gnt  (pick)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick[k]) begin
        sel_dvd = dividend_i[32*k +: 32];
        sel_dvs = divisor_i[32*k +: 32];
      end
    end
  end

  // No grant while ack is still showing, so a requester can drop req after seeing it.
  assign start      = (state == S_IDLE) && (req != '0) && (ack == '0);
  assign sel_zero   = (sel_dvs == 32'h0000_0000);
  assign valid_rise = div_valid && !valid_q;

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == S_WAIT && !valid_rise) begin
      to_cnt <= to_cnt + CW'(1);
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = (state == S_WAIT) && !valid_rise && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = sel_zero ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: begin
        if (valid_rise || timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The operand latch is the divider bus itself, loaded on the IDLE->LOAD edge so LOAD presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ack          <= '0;
      quotient     <= '0;
      warn         <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      last_grant   <= LAST_RST;
      valid_q      <= 1'b0;
    end else begin
      state   <= state_nxt;
      valid_q <= div_valid;
      ack     <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            last_grant <= pick;
            if (sel_zero) begin
              quotient <= Q16_SAT;
              warn     <= 1'b1;
            end else begin
              div_dividend <= sel_dvd;
              div_divisor  <= sel_dvs;
            end
          end
        end
        S_WAIT: begin
          if (valid_rise) begin
            quotient <= div_quotient;
            warn     <= 1'b0;
          end else if (timeout_hit) begin
            quotient <= '0;
            warn     <= 1'b1;
          end
        end
        S_DONE:  ack <= last_grant;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one Q16.16 divider.
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles allowed for one division.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req, input, N_REQ bits: per-requester request level.
REQ-006 SHALL have port dividend_i, input, 32*N_REQ bits: packed Q16.16 dividends, slot k at [32k+31:32k].
REQ-007 SHALL have port divisor_i, input, 32*N_REQ bits: packed Q16.16 divisors, same packing as dividend_i.
REQ-008 SHALL have port ack, output, N_REQ bits: one-hot, one-cycle completion pulse.
REQ-009 SHALL have port quotient, output, 32 bits: result, valid only while ack is nonzero.
REQ-010 SHALL have port warn, output, 1 bit: result is saturated or invalid, valid only with ack.
REQ-011 SHALL have port div_dividend, output, 32 bits: operand driven to the shared divider.
REQ-012 SHALL have port div_divisor, output, 32 bits: operand driven to the shared divider.
REQ-013 SHALL have port div_valid, input, 1 bit: divider result-valid level.
REQ-014 SHALL have port div_quotient, input, 32 bits: divider result.

Function
REQ-015 SHALL implement the FSM IDLE -> LOAD -> WAIT -> DONE -> IDLE.
REQ-016 IDLE SHALL grant round-robin, searching from the index after the last grant (index 0 after reset), and SHALL latch the grant index and both of that requester's operands.
REQ-017 IDLE with req==0 SHALL stay in IDLE with ack=0.
REQ-018 LOAD SHALL drive the latched operands onto div_dividend/div_divisor and go to WAIT after exactly 1 cycle, so a stale div_valid is not sampled.
REQ-019 WAIT SHALL detect a 0->1 transition of div_valid (registered previous value), capture div_quotient, and go to DONE.
REQ-020 A div_valid that is already high on WAIT entry SHALL NOT count as completion; a fresh rising edge is required.
REQ-021 DONE SHALL assert ack[grant] for exactly 1 cycle with quotient and warn, then return to IDLE.
REQ-022 A latched divisor of 32'h0000_0000 SHALL bypass LOAD/WAIT: IDLE goes directly to DONE with quotient=32'h7FFF_FFFF and warn=1.
REQ-023 Minimum request-to-ack latency SHALL be 2 cycles for divide-by-zero and 4 cycles otherwise, given a 1-cycle divider.
REQ-024 Requesters SHALL hold req and operands until ack; the block ignores operand changes after latching, and a req dropped mid-operation still completes and pulses ack.
REQ-025 A new grant SHALL NOT occur in the cycle ack is asserted.
REQ-026 div_dividend/div_divisor SHALL hold their last values outside LOAD/WAIT.

Reset
REQ-027 rst_n low SHALL immediately force the following: state=IDLE, ack=0, quotient=0, warn=0, div_dividend=0, div_divisor=0, last-grant pointer=N_REQ-1, timeout counter=0, previous div_valid=0.
REQ-028 Reset mid-operation SHALL abandon the operation without any ack.

Configuration
REQ-029 With DIV_SCHED_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT; when it reaches TIMEOUT with no rising edge, the FSM goes to DONE with quotient=0 and warn=1.
REQ-030 Without DIV_SCHED_TIMEOUT_EN, the counter SHALL be absent and WAIT waits indefinitely.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding, the Q16.16 ONE (32'h0001_0000) constant and the saturation constant (32'h7FFF_FFFF).
REQ-032 The round-robin priority picker SHALL be a sub-module, rr_pick, with N_REQ-bit request/last-grant in and one-hot grant out.

Verification
REQ-033 req=4'b0001, 1.0/2.0, divider valid rises 3 cycles after operands -> ack=4'b0001 once, quotient=32'h0000_8000, warn=0.
REQ-034 req=4'b1111 held continuously -> acks in order 0,1,2,3,0, no ack in consecutive cycles.
REQ-035 req[2], divisor=0 -> ack[2] 2 cycles later, quotient=32'h7FFF_FFFF, warn=1, div_dividend/div_divisor unchanged.
REQ-036 div_valid held high throughout -> no ack; with DIV_SCHED_TIMEOUT_EN, ack after TIMEOUT=64 WAIT cycles with quotient=0, warn=1.
REQ-037 rst_n pulsed low during WAIT -> ack never pulses, all outputs 0, next grant goes to requester 0.
